// File: rtl/dmem_sram_responder.sv
// Data-memory responder for the M-stage SRAM port: word RAM with byte strobes,
// fixed-latency access with mem_stall. Optional macro DMEM_BOUND_CHECK_EN adds addr_err.
module dmem_sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
`ifdef DMEM_BOUND_CHECK_EN
    output logic        addr_err,
`endif
    output logic        mem_stall
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_oob;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wen;
    logic [31:0]         r_rdata;
    logic                r_addr_err;
    logic [31:0]         r_mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]   w_idx_in;
    logic                w_oob_in;
    logic                w_go;
    logic [ADDR_W-1:0]   w_idx;
    logic [3:0]          w_wen;
    logic [31:0]         w_wdata;
    logic                w_oob;
    logic                w_write;
    logic                w_read;

    assign w_idx_in = mem_addr[ADDR_W+1:2];
`ifdef DMEM_BOUND_CHECK_EN
    assign w_oob_in = |mem_addr[31:ADDR_W+2];
    assign addr_err = r_addr_err;
`else
    assign w_oob_in = 1'b0;
`endif

    // With a single wait cycle the access happens straight from the port in IDLE.
    always_comb begin
        w_go    = 1'b0;
        w_idx   = r_idx;
        w_wen   = r_wen;
        w_wdata = r_wdata;
        w_oob   = r_oob;
        if (r_state == IDLE) begin
            w_idx   = w_idx_in;
            w_wen   = mem_wen;
            w_wdata = mem_wdata;
            w_oob   = w_oob_in;
            w_go    = mem_en && (WAIT_CYCLES == 1);
        end else if (r_state == BUSY) begin
            w_go    = (r_cnt == 4'd0);
        end
        w_go = w_go && resetn;
    end

    assign w_write = w_go && (w_wen != 4'd0) && !w_oob;
    assign w_read  = w_go && (w_wen == 4'd0);

    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wen[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_oob      <= 1'b0;
            r_wdata    <= 32'h0;
            r_wen      <= 4'h0;
            r_rdata    <= 32'h0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_go && w_oob;
            if (w_read) r_rdata <= w_oob ? 32'h0 : r_mem[w_idx];
            case (r_state)
                IDLE: if (mem_en) begin
                    r_idx   <= w_idx_in;
                    r_oob   <= w_oob_in;
                    r_wdata <= mem_wdata;
                    r_wen   <= mem_wen;
                    if (WAIT_CYCLES == 1) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= 4'(WAIT_CYCLES - 2);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) r_state <= RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_rdata = r_rdata;

    always_comb begin
        mem_stall = 1'b0;
        if (resetn) begin
            case (r_state)
                IDLE:    mem_stall = mem_en;
                BUSY:    mem_stall = 1'b1;
                default: mem_stall = 1'b0;
            endcase
        end
    end
endmodule
